// File: rtl/iiitb_rv32i_pkg.sv
// iiitb_rv32i_pkg: shared encodings, ALU ops, pipeline register types and decode for the rv32i core
package iiitb_rv32i_pkg;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_W   = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT} alu_op_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] ir;
    } if_id_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rd;
        alu_op_t     alu_op;
        logic        use_imm;
        logic        reg_wr;
        logic        mem_rd;
        logic        mem_wr;
        logic        br;
        logic        bne;
    } id_ex_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] res;
        logic [31:0] sdata;
        logic [4:0]  rd;
        logic        reg_wr;
        logic        mem_rd;
        logic        mem_wr;
    } ex_mem_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
        logic [4:0]  rd;
        logic        reg_wr;
    } mem_wb_t;

    localparam if_id_t IF_ID_NOP = '{valid: 1'b0, pc: 32'd0, ir: NOP};

    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3, logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OP_R};
    endfunction

    function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                          logic [4:0] rd, logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, F3_W, imm[4:0], OP_SW};
    endfunction

    // off holds imm[12:1]; branch offsets are always even
    function automatic logic [31:0] enc_b(logic [11:0] off, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3);
        return {off[11], off[9:4], rs2, rs1, f3, off[3:0], off[10], OP_BR};
    endfunction

    function automatic id_ex_t decode(if_id_t f, logic [31:0] a, logic [31:0] b);
        id_ex_t d;
        logic [6:0] op;
        logic [6:0] f7;
        logic [2:0] f3;
        op = f.ir[6:0];
        f3 = f.ir[14:12];
        f7 = f.ir[31:25];
        d = '0;
        d.valid = f.valid;
        d.pc = f.pc;
        d.a = a;
        d.b = b;
        d.rd = f.ir[11:7];
        d.imm = {{20{f.ir[31]}}, f.ir[31:20]};
        d.use_imm = 1'b1;
        case (op)
            OP_R: begin
                d.use_imm = 1'b0;
                d.reg_wr = (f7 == F7_BASE && f3 inside {F3_ADD, F3_SLT, F3_XOR, F3_OR, F3_AND}) ||
                           (f7 == F7_SUB && f3 == F3_ADD);
                d.alu_op = f7 == F7_SUB ? ALU_SUB : f3 == F3_SLT ? ALU_SLT : f3 == F3_XOR ? ALU_XOR :
                           f3 == F3_OR ? ALU_OR : f3 == F3_AND ? ALU_AND : ALU_ADD;
            end
            OP_I: d.reg_wr = f3 == F3_ADD;
            OP_LW: begin
                d.reg_wr = f3 == F3_W;
                d.mem_rd = f3 == F3_W;
            end
            OP_SW: begin
                d.mem_wr = f3 == F3_W;
                d.imm = {{20{f.ir[31]}}, f.ir[31:25], f.ir[11:7]};
            end
            OP_BR: begin
                d.use_imm = 1'b0;
                d.alu_op = ALU_SUB;
                d.br = f3 == F3_BEQ || f3 == F3_BNE;
                d.bne = f3 == F3_BNE;
                d.imm = {{19{f.ir[31]}}, f.ir[31], f.ir[7], f.ir[30:25], f.ir[11:8], 1'b0};
            end
            default: ;
        endcase
        d.reg_wr = d.reg_wr && d.rd != 5'd0;
        if (!f.valid)
            d = '0;
        return d;
    endfunction

endpackage

// File: rtl/iiitb_rv32i_alu.sv
// iiitb_rv32i_alu: combinational integer ALU with equality and signed less-than flags
module iiitb_rv32i_alu
    import iiitb_rv32i_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_t     op,
    output logic [31:0] y,
    output logic        zero,
    output logic        lt
);
    // SLT shares the subtractor; the 0/1 result is formed from lt by the caller
    always_comb begin
        y = op == ALU_ADD ? a + b : op == ALU_AND ? a & b : op == ALU_OR ? a | b :
            op == ALU_XOR ? a ^ b : a - b;
        zero = y == 32'd0;
        lt = $signed(a) < $signed(b);
    end
endmodule

// File: rtl/iiitb_rv32i.sv
// iiitb_rv32i: five-stage in-order RV32I-subset core with internal ROM, data RAM and register file
module iiitb_rv32i
    import iiitb_rv32i_pkg::*;
#(
    parameter int IMEM_DEPTH = 32,
    parameter int DMEM_DEPTH = 32
) (
    input  logic        clk,
    input  logic        RN,
    output logic [31:0] NPC,
    output logic [31:0] WB_OUT
);
    localparam int IW = $clog2(IMEM_DEPTH);
    localparam int DW = $clog2(DMEM_DEPTH);

    logic [31:0] pc;
    if_id_t if_id;
    id_ex_t id_ex;
    ex_mem_t ex_mem;
    mem_wb_t mem_wb;
    logic [31:0][31:0] rf;
    logic [DMEM_DEPTH-1:0][31:0] dmem;

    logic [4:0] rs1, rs2;
    logic [31:0] rs1_val, rs2_val, alu_b, alu_y, ex_res, target;
    logic alu_zero, alu_lt, taken, wb_en;

    function automatic logic [31:0] rom(int i);
        case (i)
            0: return enc_i(12'd5, 5'd0, F3_ADD, 5'd1, OP_I);
            1: return enc_i(12'd3, 5'd0, F3_ADD, 5'd2, OP_I);
            2: return enc_i(12'hfff, 5'd0, F3_ADD, 5'd4, OP_I);
            4: return enc_r(F7_BASE, 5'd2, 5'd1, F3_ADD, 5'd3);
            5: return enc_r(F7_SUB, 5'd2, 5'd1, F3_ADD, 5'd5);
            6: return enc_r(F7_BASE, 5'd2, 5'd1, F3_AND, 5'd6);
            7: return enc_r(F7_BASE, 5'd2, 5'd1, F3_OR, 5'd7);
            8: return enc_r(F7_BASE, 5'd2, 5'd1, F3_XOR, 5'd8);
            9: return enc_r(F7_BASE, 5'd1, 5'd4, F3_SLT, 5'd9);
            10: return enc_s(12'd0, 5'd3, 5'd0);
            11: return enc_i(12'd0, 5'd0, F3_W, 5'd10, OP_LW);
            12: return enc_b(12'd0, 5'd0, 5'd0, F3_BEQ);
            default: return NOP;
        endcase
    endfunction

    // write-through: a value retiring this cycle is seen by the decode-stage read
    assign wb_en = mem_wb.valid && mem_wb.reg_wr;
    assign rs1 = if_id.ir[19:15];
    assign rs2 = if_id.ir[24:20];
    assign rs1_val = rs1 == 5'd0 ? 32'd0 : (wb_en && mem_wb.rd == rs1) ? mem_wb.data : rf[rs1];
    assign rs2_val = rs2 == 5'd0 ? 32'd0 : (wb_en && mem_wb.rd == rs2) ? mem_wb.data : rf[rs2];

    assign alu_b = id_ex.use_imm ? id_ex.imm : id_ex.b;

    iiitb_rv32i_alu u_alu (
        .a    (id_ex.a),
        .b    (alu_b),
        .op   (id_ex.alu_op),
        .y    (alu_y),
        .zero (alu_zero),
        .lt   (alu_lt)
    );

    assign ex_res = id_ex.alu_op == ALU_SLT ? {31'd0, alu_lt} : alu_y;
    assign taken = id_ex.valid && id_ex.br && (alu_zero ^ id_ex.bne);
    assign target = id_ex.pc + id_ex.imm;
    assign NPC = pc;

    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            pc <= 32'd0;
            if_id <= IF_ID_NOP;
            id_ex <= '0;
            ex_mem <= '0;
            mem_wb <= '0;
            rf <= '0;
            dmem <= '0;
            WB_OUT <= 32'd0;
        end else begin
            pc <= taken ? target : pc + 32'd4;
            if_id <= taken ? IF_ID_NOP : '{valid: 1'b1, pc: pc, ir: rom(int'(pc[IW+1:2]))};
            id_ex <= taken ? '0 : decode(if_id, rs1_val, rs2_val);
            ex_mem <= '{valid: id_ex.valid, res: ex_res, sdata: id_ex.b, rd: id_ex.rd,
                        reg_wr: id_ex.reg_wr, mem_rd: id_ex.mem_rd, mem_wr: id_ex.mem_wr};
            mem_wb <= '{valid: ex_mem.valid, rd: ex_mem.rd, reg_wr: ex_mem.reg_wr,
                        data: ex_mem.mem_rd ? dmem[ex_mem.res[DW+1:2]] : ex_mem.res};
            if (ex_mem.valid && ex_mem.mem_wr)
                dmem[ex_mem.res[DW+1:2]] <= ex_mem.sdata;
            if (wb_en) begin
                rf[mem_wb.rd] <= mem_wb.data;
                WB_OUT <= mem_wb.data;
            end
        end
    end
endmodule

// File: tb/tb_iiitb_rv32i.sv
// tb_iiitb_rv32i: runs the fixed program from randomly timed resets and checks NPC/WB_OUT every edge
module tb_iiitb_rv32i;
    logic clk, RN;
    logic [31:0] NPC, WB_OUT;
    int tests = 0;
    int fails = 0;

    iiitb_rv32i dut (
        .clk    (clk),
        .RN     (RN),
        .NPC    (NPC),
        .WB_OUT (WB_OUT)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // fetch address after edge n: straight-line up to the BEQ at 48, then a 3-edge loop
    function automatic logic [31:0] exp_npc(int n);
        return n < 15 ? 32'(4 * n) : 32'(48 + 4 * ((n - 15) % 3));
    endfunction

    // program-level results: instruction i retires on edge i+5; nothing retires after the loop starts
    function automatic logic [31:0] exp_wb(int n);
        int x1 = 5;
        int x2 = 3;
        int x4 = -1;
        logic [31:0] v = 32'd0;
        logic [31:0] r[12];
        bit w[12] = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 0, 1};
        r = '{32'(x1), 32'(x2), 32'(x4), 32'd0, 32'(x1 + x2), 32'(x1 - x2), 32'(x1 & x2),
              32'(x1 | x2), 32'(x1 ^ x2), 32'(x4 < x1), 32'd0, 32'(x1 + x2)};
        for (int i = 0; i < 12; i++)
            if (w[i] && i + 5 <= n)
                v = r[i];
        return v;
    endfunction

    task automatic run(input int len);
        for (int n = 1; n <= len; n++) begin
            @(posedge clk);
            #1;
            check($sformatf("npc@%0d", n), NPC, exp_npc(n));
            check($sformatf("wb@%0d", n), WB_OUT, exp_wb(n));
        end
    endtask

    task automatic reset_pulse();
        #($urandom_range(1, 3));
        RN = 1'b0;
        #1;
        check("async_npc", NPC, 32'd0);
        check("async_wb", WB_OUT, 32'd0);
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
            check("hold_npc", NPC, 32'd0);
            check("hold_wb", WB_OUT, 32'd0);
        end
        @(negedge clk);
        RN = 1'b1;
    endtask

    initial begin
        RN = 1'b0;
        #1;
        check("reset_npc", NPC, 32'd0);
        check("reset_wb", WB_OUT, 32'd0);
        #4;
        RN = 1'b1;
        run(40);
        repeat (8) begin
            reset_pulse();
            run($urandom_range(3, 40));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
